// File: rtl/fp8_pkg.sv
// Shared minifloat definitions: default E4M3 format constants, max-magnitude helper
// and the unpacked-operand view used between pipeline stages.
package fp8_pkg;

    localparam int unsigned EXP_BITS_DEF = 4;
    localparam int unsigned MAN_BITS_DEF = 3;
    localparam int          BIAS_DEF     = (1 << (EXP_BITS_DEF - 1)) - 1;

    // Unpacked operand in the default format: exp is the signed working exponent,
    // sig the full significand product with the hidden bits included.
    typedef struct packed {
        logic                                sign;
        logic                                zero;
        logic signed [EXP_BITS_DEF+1:0]      exp;
        logic        [2*MAN_BITS_DEF+1:0]    sig;
    } fp_unpacked_t;

    // Exponent all-ones with mantissa all-ones, sign excluded.
    function automatic logic [31:0] fp_max_mag(input int unsigned exp_bits,
                                               input int unsigned man_bits);
        return (32'd1 << (exp_bits + man_bits)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp8_round_norm.sv
// Combinational normalise + round-to-nearest-even of an exact significand product.
// Shared with future adder/MAC datapaths.
module fp_round_norm
    import fp8_pkg::*;
#(
    parameter int unsigned EXP_BITS = EXP_BITS_DEF,
    parameter int unsigned MAN_BITS = MAN_BITS_DEF,
    localparam int unsigned EW = EXP_BITS + 2,
    localparam int unsigned PW = 2 * MAN_BITS + 2
) (
    input  logic [PW-1:0]       sig,
    input  logic [EW-1:0]       exp_in,
    output logic [MAN_BITS-1:0] man,
    output logic [EW-1:0]       exp_out
);

    logic [PW-2:0]     frac;
    logic [MAN_BITS-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              rnd;
    logic [MAN_BITS:0] mant_r;

    always_comb begin
        // Drop the hidden one; a product in [2,4) is already aligned, [1,2) shifts left.
        frac    = sig[PW-1] ? sig[PW-2:0] : {sig[PW-3:0], 1'b0};
        mant    = frac[PW-2 -: MAN_BITS];
        guard   = frac[MAN_BITS];
        sticky  = |frac[MAN_BITS-1:0];
        rnd     = guard & (sticky | mant[0]);
        mant_r  = {1'b0, mant} + {{MAN_BITS{1'b0}}, rnd};
        man     = mant_r[MAN_BITS-1:0];
        exp_out = exp_in + EW'(sig[PW-1]) + EW'(mant_r[MAN_BITS]);
    end

endmodule

// File: rtl/fp8_mul_pipe.sv
// Three-stage minifloat multiplier (unpack/multiply, normalise/round, pack/classify)
// with a valid/ready stream interface; all stages advance together.
module fp8_mul_pipe
    import fp8_pkg::*;
#(
    parameter int unsigned EXP_BITS = EXP_BITS_DEF,
    parameter int unsigned MAN_BITS = MAN_BITS_DEF,
    parameter int          BIAS     = (1 << (EXP_BITS - 1)) - 1,
    localparam int unsigned W = 1 + EXP_BITS + MAN_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_unf
);

    localparam int unsigned EW = EXP_BITS + 2;
    localparam int unsigned PW = 2 * MAN_BITS + 2;
    localparam logic [EW-1:0]  BIAS_V  = EW'(BIAS);
    localparam logic [EW-1:0]  EMAX    = EW'((1 << EXP_BITS) - 1);
    localparam logic [W-2:0]   MAX_MAG = (W-1)'(fp_max_mag(EXP_BITS, MAN_BITS));

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic [EW-1:0] exp;
        logic [PW-1:0] sig;
    } s1_t;

    logic                en;
    logic                v1, v2;
    s1_t                 s1_c, s1_q;
    logic                s2_sign, s2_zero;
    logic [EW-1:0]       s2_exp;
    logic [MAN_BITS-1:0] s2_man;
    logic [MAN_BITS-1:0] rn_man;
    logic [EW-1:0]       rn_exp;
    logic [W-1:0]        pk_data;
    logic                pk_ovf, pk_unf;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        s1_c.sign = a[W-1] ^ b[W-1];
        s1_c.zero = (a[W-2 -: EXP_BITS] == '0) | (b[W-2 -: EXP_BITS] == '0);
        s1_c.sig  = PW'({1'b1, a[MAN_BITS-1:0]}) * PW'({1'b1, b[MAN_BITS-1:0]});
        s1_c.exp  = EW'(a[W-2 -: EXP_BITS]) + EW'(b[W-2 -: EXP_BITS]) - BIAS_V;
    end

    fp_round_norm #(.EXP_BITS(EXP_BITS), .MAN_BITS(MAN_BITS)) u_round_norm (
        .sig     (s1_q.sig),
        .exp_in  (s1_q.exp),
        .man     (rn_man),
        .exp_out (rn_exp)
    );

    always_comb begin
        pk_ovf  = 1'b0;
        pk_unf  = 1'b0;
        pk_data = {s2_sign, {(W-1){1'b0}}};
        if (s2_zero) begin
            pk_data = {s2_sign, {(W-1){1'b0}}};
        end else if ($signed(s2_exp) <= 0) begin
            pk_unf = 1'b1;
        end else if ($signed(s2_exp) > $signed(EMAX)) begin
            pk_ovf  = 1'b1;
            pk_data = {s2_sign, MAX_MAG};
        end else begin
            pk_data = {s2_sign, s2_exp[EXP_BITS-1:0], s2_man};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            s1_q      <= '0;
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_exp    <= '0;
            s2_man    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            s1_q      <= s1_c;
            v2        <= v1;
            s2_sign   <= s1_q.sign;
            s2_zero   <= s1_q.zero;
            s2_exp    <= rn_exp;
            s2_man    <= rn_man;
            out_valid <= v2;
            out_data  <= pk_data;
            out_ovf   <= pk_ovf;
            out_unf   <= pk_unf;
        end
    end

endmodule

// File: tb/tb_fp8_mul_pipe.sv
// Scoreboard bench for fp8_mul_pipe (E4M3): directed vectors, backpressure and async reset.
module tb_fp8_mul_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf, out_unf;

    fp8_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       unf;
        int         t_acc;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   lat_chk = 1'b1;

    // a, b, expected product, expected ovf, expected unf
    localparam int NV = 16;
    logic [7:0] tv_a [NV] = '{8'h3C, 8'h38, 8'h38, 8'h38, 8'h38, 8'h39, 8'h3A, 8'h3E,
                              8'h39, 8'hB8, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h08, 8'h88};
    logic [7:0] tv_b [NV] = '{8'h3C, 8'h38, 8'h38, 8'h38, 8'h38, 8'h39, 8'h3A, 8'h3A,
                              8'h3E, 8'h38, 8'h7F, 8'h38, 8'h7F, 8'h7F, 8'h08, 8'h08};
    logic [7:0] tv_p [NV] = '{8'h41, 8'h38, 8'h38, 8'h38, 8'h38, 8'h3A, 8'h3C, 8'h41,
                              8'h40, 8'hB8, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h80};
    logic       tv_o [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    logic       tv_u [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer, in_valid left high.
    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                        input logic eo, input logic eu);
        int tries = 0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        #1;
        while (!in_ready) begin
            tries++;
            if (tries > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck 0 for a=0x%0h b=0x%0h", va, vb);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        sb.push_back('{data: ed, ovf: eo, unf: eu, t_acc: cyc, chk_lat: lat_chk});
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops on every output transfer, checks output stability while stalled.
    exp_t       mon_e;
    bit         held_v = 1'b0;
    logic [9:0] held;
    always begin
        @(negedge clk);
        #2;
        if (out_valid && !out_ready) begin
            if (held_v) check("stall_hold", 32'({out_data, out_ovf, out_unf}), 32'(held));
            held   = {out_data, out_ovf, out_unf};
            held_v = 1'b1;
        end else begin
            held_v = 1'b0;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_output: got 0x%0h with no result pending", out_data);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'({out_data, out_ovf, out_unf}),
                      32'({mon_e.data, mon_e.ovf, mon_e.unf}));
                if (mon_e.chk_lat) check("latency", 32'(cyc - mon_e.t_acc), 32'd3);
            end
        end
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #12;
        check("reset_state", 32'({out_valid, out_data, out_ovf, out_unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors, streamed back to back with the sink always ready.
        for (int i = 0; i < NV; i++) send(tv_a[i], tv_b[i], tv_p[i], tv_o[i], tv_u[i]);
        in_valid = 1'b0;
        drain();

        // Backpressure: sink stalls 4 cycles from the first output.
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(tv_a[i+5], tv_b[i+5], tv_p[i+5], 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 30 && !seen; k++) begin
                    @(negedge clk);
                    #2;
                    if (out_valid) seen = 1'b1;
                end
                check("bp_out_valid_seen", 32'(seen), 32'd1);
                check("bp_in_ready_drop", 32'(in_ready), 32'd0);
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Async reset with results in flight.
        out_ready = 1'b0;
        lat_chk   = 1'b1;
        send(8'h39, 8'h39, 8'h3A, 1'b0, 1'b0);
        send(8'h3A, 8'h3A, 8'h3C, 1'b0, 1'b0);
        send(8'h3E, 8'h3A, 8'h41, 1'b0, 1'b0);
        in_valid = 1'b0;
        #3;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 32'({out_valid, out_data, out_ovf, out_unf}), 32'd0);
        sb.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_idle", 32'(out_valid), 32'd0);
        send(8'h3C, 8'h3C, 8'h41, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp8_mul_pipe.md
Name: fp8_mul_pipe

Overview:
- Pipelined, parametrised minifloat multiplier with exact significand product and round-to-nearest-even.
- Adds valid/ready streaming handshake with backpressure, a 3-stage pipeline, and overflow/underflow flags.
- Successor to the combinational approximate FP8 multiplier. It sits between the operand source (pins or a feeder FSM) and the result sink.
- Default format is E4M3: sign | exponent | mantissa, MSB first.

Parameters:
- EXP_BITS, 4, exponent field width (>=3).
- MAN_BITS, 3, mantissa field width (>=2).
- BIAS, (1<<(EXP_BITS-1))-1, exponent bias.
- W (derived, localparam), 1+EXP_BITS+MAN_BITS, word width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_data  out  W  product.
- out_ovf  out  1  overflow saturated (qualified by out_valid).
- out_unf  out  1  underflow flushed to zero (qualified by out_valid).

Behaviour:
- Reset (async, rst_n=0): all stage valid bits = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_unf = 0. Reset mid-operation discards all in-flight results. No output appears after release until new input is accepted.
- Pipeline advance: en = ~out_valid | out_ready. in_ready = en (combinational). All three stages shift together when en=1 and hold when en=0. Bubbles are not compressed.
- Transfers: an input transfer occurs on in_valid & in_ready. An output transfer occurs on out_valid & out_ready. out_data and flags are stable while out_valid=1 and out_ready=0.
- Latency: exactly 3 cycles from input accept to out_valid when unstalled. Throughput is 1 result per cycle.
- Encoding:
  - Exponent field 0 means zero; the mantissa is ignored, so there are no subnormals.
  - All other exponent codes are normal. There is no Inf or NaN; all-ones exponent is normal.
  - Max magnitude is exponent all-ones with mantissa all-ones (0x7F/0xFF for E4M3).
- S1 (unpack/multiply):
  - s = Sa^Sb.
  - zero flag = (Ea==0)|(Eb==0).
  - p = {1,Ma}*{1,Mb}, 2*MAN_BITS+2 bits.
  - e = Ea+Eb-BIAS, signed, EXP_BITS+2 bits.
- S2 (normalise/round):
  - If p MSB = 1: take significand from p[top-1 ...] and add 1 to e. Otherwise shift left one.
  - Keep MAN_BITS fraction bits, plus a guard bit and a sticky bit (OR of the remainder).
  - Round to nearest even: increment when guard & (sticky | lsb).
  - If the increment carries out, the mantissa becomes 0 and e += 1.
- S3 (pack/classify), in priority order:
  1. Zero input: out = {s, 0...}, no flags.
  2. e <= 0: out = {s, 0...}, out_unf = 1.
  3. e > 2^EXP_BITS-1: out = {s, max magnitude}, out_ovf = 1.
  4. Otherwise: out = {s, e[EXP_BITS-1:0], mantissa}.
- Sign of zero and saturated results is always Sa^Sb.
- Simultaneous input accept and output accept in the same cycle is legal and is the normal streaming case.

Decomposition:
- Shared package fp8_pkg holds:
  - constants EXP_BITS_DEF, MAN_BITS_DEF, BIAS_DEF
  - function fp_max_mag
  - an unpacked-operand typedef {sign, zero, exp, sig}
- One natural sub-module: fp_round_norm, the combinational normalise+round used in S2. It is reusable by a future adder/MAC.
- Pipeline registers and handshake stay in fp8_mul_pipe.

Test Plan (E4M3, BIAS=7):
- Basic, streaming: a=0x3C (1.5), b=0x3C -> out_data=0x41 (2.25), no flags, out_valid exactly 3 cycles after accept. Back-to-back 1.0*1.0 (0x38*0x38) -> 0x38 on every cycle.
- Rounding: 0x39*0x39 (1.125^2) -> 0x3A (sticky round-down). 0x3A*0x3A (1.25^2, exact tie) -> 0x3C (even kept). 0x3E*0x3A (1.75*1.25) -> 0x41 (round-up).
- Sign/zero: 0xB8*0x38 -> 0xB8. 0x00*0x7F -> 0x00. 0x80*0x38 -> 0x80, no flags.
- Saturation/underflow: 0x7F*0x7F -> 0x7F with out_ovf=1. 0xFF*0x7F -> 0xFF with out_ovf=1. 0x08*0x08 -> 0x00 with out_unf=1. 0x88*0x08 -> 0x80 with out_unf=1.
- Backpressure: stream 5 operand pairs and hold out_ready=0 for 4 cycles once out_valid=1.
  - in_ready drops the same cycle out_valid rises.
  - out_data is held stable.
  - After out_ready=1, all 5 results arrive in order with none lost or duplicated.
- Reset mid-flight: accept 3 pairs, assert rst_n=0 for 1 cycle between clock edges.
  - out_valid, out_data and flags clear immediately (async).
  - After release there is no output until a new accept, then the correct result arrives 3 cycles later.
